gate_compare_unit: RTL and testbench
====================================

GATE_COMPARE_UNIT -- requirements
Module: gate_compare_unit

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits, legal range 1..8.
REQ-002 Parameter CNT_W, default 16, width of the error counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 mode  input  1  operation type: 0 = single evaluation, 1 = exhaustive sweep.
REQ-007 op  input  3  logic function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 pass a.
REQ-008 a_in, b_in  input  WIDTH each  operands for single mode.
REQ-009 inject_fault  input  1  when 1, inverts bit 0 of the structural path output (test hook).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking operation completion.
REQ-012 result  output  WIDTH  registered structural-path result of the last evaluation.
REQ-013 mismatch  output  1  sticky flag: structural and behavioural results differed.
REQ-014 err_count  output  CNT_W  number of mismatching evaluations in the current operation.

Function
REQ-015 Every result is computed twice, bitwise: structural path (NOR primitives only) and behavioural path (operator expression).
REQ-016 FSM states: IDLE, EVAL, SWEEP, DONE.
REQ-017 IDLE transitions on start=1: mode=0 -> EVAL, mode=1 -> SWEEP.
REQ-018 The start edge captures op, plus a_in/b_in when mode=0; later input changes are ignored until the next start.
REQ-019 The start edge clears mismatch, clears err_count, and sets the sweep counter cnt (2*WIDTH bits) to 0.
REQ-020 EVAL lasts one cycle: register result, compare both paths, update flags, go to DONE.
REQ-021 Single-mode latency: start sampled at edge k; result valid and done=1 after edge k+1.
REQ-022 SWEEP evaluates a=cnt[WIDTH-1:0], b=cnt[2*WIDTH-1:WIDTH] each cycle, registers result, compares, then increments cnt.
REQ-023 SWEEP moves to DONE in the cycle it evaluates cnt = all-ones, giving exactly 2^(2*WIDTH) evaluation cycles; cnt does not wrap.
REQ-024 Each mismatching evaluation sets mismatch and increments err_count, which saturates at all-ones.
REQ-025 DONE lasts one cycle, drives done=1, then returns to IDLE; done is 0 in all other states.
REQ-026 start while busy=1 is ignored and never queued.
REQ-027 start asserted in the DONE cycle is ignored; the earliest accepted start is the first cycle in IDLE.
REQ-028 result, mismatch and err_count hold their values in IDLE until the next accepted start.
REQ-029 inject_fault is sampled combinationally in every evaluation cycle.

Reset
REQ-030 rst_n=0 immediately forces state IDLE, busy=0, done=0, result=0, mismatch=0, err_count=0, cnt=0, regardless of clk.
REQ-031 Reset asserted mid-EVAL or mid-SWEEP aborts the operation with no done pulse; the first start after deassertion begins a fresh operation.

Structure
REQ-032 A shared package gate_compare_pkg holds the op encodings, the FSM state type, and the WIDTH-range constants.
REQ-033 The structural path is the sub-module nor_gate_net: WIDTH-parameterised, purely combinational, NOR primitives only.
REQ-034 nor_gate_net is instantiated once and fed by a mux that selects the captured operands or the cnt slices.

Verification
REQ-035 WIDTH=4, mode=0, op=2, a_in=1100, b_in=1010 -> result=0111, done pulses after edge k+1, mismatch=0, err_count=0.
REQ-036 WIDTH=4, mode=0, op=6, a_in=0101 -> result=1010, mismatch=0.
REQ-037 WIDTH=4, mode=1, op=5, inject_fault=0 -> busy for 256 SWEEP cycles, then done, err_count=0, mismatch=0.
REQ-038 WIDTH=4, mode=1, op=4, inject_fault=1 -> err_count=256, mismatch=1; a following single op=0 without fault clears both to 0.
REQ-039 start pulsed during SWEEP and in the DONE cycle -> no restart; exactly one done pulse.
REQ-040 rst_n=0 at sweep cycle 100 -> all outputs 0 immediately, no done pulse; the next start runs a full 256-cycle sweep.

Source files
------------

// File: rtl/gate_compare_pkg.sv
// gate_compare_pkg: shared op encodings, FSM state type and width limits for gate_compare_unit.
package gate_compare_pkg;
    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_PASS  = 3'd7
    } op_t;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_t;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 8;
endpackage

// File: rtl/nor_gate_net.sv
// nor_gate_net: bitwise logic function of a and b selected by op, built only from NOR primitives.
module nor_gate_net #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);
    logic [2:0] op_n;
    logic [7:0] sel;
    logic [7:0] sel_n;
    nor (op_n[0], op[0], op[0]);
    nor (op_n[1], op[1], op[1]);
    nor (op_n[2], op[2], op[2]);
    // one-hot op decode: sel[k] is the NOR of the literals that must be 0 for op == k
    for (genvar k = 0; k < 8; k++) begin : g_dec
        localparam logic [2:0] K = 3'(k);
        nor (sel[k], K[0] ? op_n[0] : op[0], K[1] ? op_n[1] : op[1], K[2] ? op_n[2] : op[2]);
        nor (sel_n[k], sel[k], sel[k]);
    end
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        logic na, nb, f_nor, f_or, f_and, f_nand, f_xor, f_xnor, f_pass, y_n;
        logic [7:0] f;
        logic [7:0] f_n;
        logic [7:0] t;
        nor (na, a[j], a[j]);
        nor (nb, b[j], b[j]);
        nor (f_nor, a[j], b[j]);
        nor (f_or, f_nor, f_nor);
        nor (f_and, na, nb);
        nor (f_nand, f_and, f_and);
        nor (f_xor, f_and, f_nor);
        nor (f_xnor, f_xor, f_xor);
        nor (f_pass, na, na);
        assign f = {f_pass, na, f_xnor, f_xor, f_nor, f_nand, f_or, f_and};
        for (genvar k = 0; k < 8; k++) begin : g_term
            nor (f_n[k], f[k], f[k]);
            nor (t[k], sel_n[k], f_n[k]);
        end
        nor (y_n, t[0], t[1], t[2], t[3], t[4], t[5], t[6], t[7]);
        nor (y[j], y_n, y_n);
    end
endmodule

// File: rtl/gate_compare_unit.sv
// gate_compare_unit: evaluates a logic op on a NOR-only net and an operator expression, flagging disagreement.
module gate_compare_unit
    import gate_compare_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             inject_fault,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);
    localparam int CW = 2 * WIDTH;
    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] in_a, in_b, net_y, s_res, b_res;
    logic             eval, diff;
    assign eval  = state == S_EVAL || state == S_SWEEP;
    assign in_a  = state == S_SWEEP ? cnt[WIDTH-1:0] : a_q;
    assign in_b  = state == S_SWEEP ? cnt[CW-1:WIDTH] : b_q;
    nor_gate_net #(.WIDTH(WIDTH)) u_net (
        .a  (in_a),
        .b  (in_b),
        .op (op_q),
        .y  (net_y)
    );
    assign s_res = net_y ^ WIDTH'(inject_fault);
    assign b_res = op_q == OP_AND   ? in_a & in_b    :
                   op_q == OP_OR    ? in_a | in_b    :
                   op_q == OP_NAND  ? ~(in_a & in_b) :
                   op_q == OP_NOR   ? ~(in_a | in_b) :
                   op_q == OP_XOR   ? in_a ^ in_b    :
                   op_q == OP_XNOR  ? ~(in_a ^ in_b) :
                   op_q == OP_NOT_A ? ~in_a          : in_a;
    assign diff  = s_res != b_res;
    assign busy  = state != S_IDLE;
    assign done  = state == S_DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_AND;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            result    <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            if (eval) begin
                result <= s_res;
                if (diff) begin
                    mismatch <= 1'b1;
                    if (~&err_count) err_count <= err_count + CNT_W'(1);
                end
            end
            case (state)
                S_IDLE: if (start) begin
                    op_q      <= op_t'(op);
                    a_q       <= mode ? a_q : a_in;
                    b_q       <= mode ? b_q : b_in;
                    cnt       <= '0;
                    mismatch  <= 1'b0;
                    err_count <= '0;
                    state     <= mode ? S_SWEEP : S_EVAL;
                end
                S_EVAL:  state <= S_DONE;
                // the last operand pair ends the sweep without advancing cnt, so it never wraps
                S_SWEEP: if (&cnt) state <= S_DONE;
                         else cnt <= cnt + CW'(1);
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_compare_unit.sv
// tb_gate_compare_unit: randomized scoreboard bench for gate_compare_unit with a truth-table reference model.
module tb_gate_compare_unit;
    localparam int W  = 4;
    localparam int CW = 16;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, inject_fault = 1'b0;
    logic [2:0]    op = '0;
    logic [W-1:0]  a_in = '0, b_in = '0;
    logic          busy, done, mismatch;
    logic [W-1:0]  result;
    logic [CW-1:0] err_count;
    typedef struct {
        logic [W-1:0]  res;
        logic          mm;
        logic [CW-1:0] ec;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, dones = 0;
    always #5 clk = ~clk;
    gate_compare_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .inject_fault (inject_fault),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mismatch     (mismatch),
        .err_count    (err_count)
    );
    function automatic logic [W-1:0] ref_fn(input int f, input int a, input int b);
        int m, r;
        m = (1 << W) - 1;
        case (f)
            0: r = a & b;
            1: r = a | b;
            2: r = m - (a & b);
            3: r = m - (a | b);
            4: r = a ^ b;
            5: r = m - (a ^ b);
            6: r = m - a;
            default: r = a;
        endcase
        return r[W-1:0];
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            dones++;
            if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("mismatch", 32'(mismatch), 32'(e.mm));
                chk("err_count", 32'(err_count), 32'(e.ec));
            end
        end
    end
    function automatic exp_t model(input logic m, input int f, input int a, input int b, input logic flt);
        exp_t e;
        int n;
        n = m ? (1 << (2 * W)) : 1;
        e.res = (m ? ref_fn(f, (1 << W) - 1, (1 << W) - 1) : ref_fn(f, a, b)) ^ W'(flt);
        e.mm  = flt;
        e.ec  = flt ? CW'(n) : '0;
        return e;
    endfunction
    task automatic run_op(input logic m, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic flt);
        exp_t e;
        int cyc;
        e = model(m, int'(f), int'(a), int'(b), flt);
        @(negedge clk);
        start = 1'b1; mode = m; op = f; a_in = a; b_in = b; inject_fault = flt;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0; mode = $urandom; op = 3'($urandom); a_in = W'($urandom); b_in = W'($urandom);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), m ? 32'd257 : 32'd2);
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("hold_result", 32'(result), 32'(e.res));
        chk("hold_err_count", 32'(err_count), 32'(e.ec));
    endtask
    initial begin
        int d0, cyc;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 3'd2, 4'b1100, 4'b1010, 1'b0);
        run_op(1'b0, 3'd6, 4'b0101, 4'b0000, 1'b0);
        run_op(1'b1, 3'd5, 4'b0000, 4'b0000, 1'b0);
        run_op(1'b1, 3'd4, 4'b0000, 4'b0000, 1'b1);
        run_op(1'b0, 3'd0, 4'b1011, 4'b0110, 1'b0);
        for (int i = 0; i < 24; i++)
            run_op(1'b0, 3'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0));
        for (int i = 0; i < 2; i++)
            run_op(1'b1, 3'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        // restart attempts during the sweep and in the DONE cycle must be ignored
        d0 = dones;
        inject_fault = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; op = 3'd1;
        q.push_back(model(1'b1, 1, 0, 0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        start = 1'b1; mode = 1'b0; op = 3'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("sweep_done_seen", 32'(done), 32'd1);
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("no_restart_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("single_done_pulse", 32'(dones - d0), 32'd1);
        chk("still_idle", 32'(busy), 32'd0);
        // asynchronous reset partway through a sweep
        d0 = dones;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; op = 3'd2; inject_fault = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_mismatch", 32'(mismatch), 32'd0);
        chk("abort_err_count", 32'(err_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        inject_fault = 1'b0;
        chk("abort_no_done", 32'(dones - d0), 32'd0);
        run_op(1'b1, 3'd7, 4'b0000, 4'b0000, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", fails);
        $fatal(1);
    end
endmodule
